// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active-low (common-anode display).
package bcd_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Anode enables indexed by digit slot; slot 0 is the units digit.
  localparam logic [NUM_DIGITS-1:0][3:0] AN_ONEHOT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // Non-decimal nibbles render as a dash so a corrupt input is visible.
  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_digit_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Ports:
//   digit - 4-bit BCD nibble (10..15 decode to a dash)
//   seg   - {g,f,e,d,c,b,a}, active-low
module bcd_digit_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = digit_to_seg(digit);

endmodule

// File: rtl/bcd_sevenseg_scan.sv
// Time-multiplexed 4-digit seven-segment driver for a common-anode display.
// Captures a packed BCD word on load and scans one digit per REFRESH_DIV cycles.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bcd   - packed BCD {thousands, hundreds, tens, units}
//   load  - capture bcd on this edge
//   blank - force display dark while high (scan keeps running)
//   an    - anode enables, active-low, an[0] = units
//   seg   - {g,f,e,d,c,b,a}, active-low
//   dp    - decimal point, active-low, always off
// Build option: define BCD_SEVENSEG_LZB_EN for leading-zero blanking.
module bcd_sevenseg_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd,
  input  logic        load,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      bcd_q;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             tick;
  logic [3:0]       digit;
  logic [6:0]       digit_seg;
  logic             lead_zero;

  assign tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  assign idx_d = tick ? idx_q + 2'd1 : idx_q;

  // Outputs are loaded from the upcoming slot, so select on idx_d.
  always_comb begin
    digit = 4'd0;
    unique case (idx_d)
      2'd0: digit = bcd_q[3:0];
      2'd1: digit = bcd_q[7:4];
      2'd2: digit = bcd_q[11:8];
      2'd3: digit = bcd_q[15:12];
    endcase
  end

  bcd_digit_decode u_decode (
    .digit (digit),
    .seg   (digit_seg)
  );

`ifdef BCD_SEVENSEG_LZB_EN
  // A slot is dark when it and every more-significant digit are zero; units always lit.
  always_comb begin
    lead_zero = 1'b0;
    unique case (idx_d)
      2'd0: lead_zero = 1'b0;
      2'd1: lead_zero = (bcd_q[15:4] == 12'h000);
      2'd2: lead_zero = (bcd_q[15:8] == 8'h00);
      2'd3: lead_zero = (bcd_q[15:12] == 4'h0);
    endcase
  end
`else
  assign lead_zero = 1'b0;
`endif

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (blank) begin
      an_d  = AN_OFF;
      seg_d = SEG_BLANK;
    end else if (tick) begin
      an_d  = lead_zero ? AN_OFF : AN_ONEHOT[idx_d];
      seg_d = lead_zero ? SEG_BLANK : digit_seg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd3;
      bcd_q <= 16'h0000;
      an_q  <= AN_OFF;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      if (load) bcd_q <= bcd;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Randomized self-checking bench for bcd_sevenseg_scan against a behavioural model.
module tb_bcd_sevenseg_scan;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd = '0;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  bcd_sevenseg_scan #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bcd   (bcd),
    .load  (load),
    .blank (blank),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // Model state: edges since reset release, captured word, expected outputs.
  int          cyc;
  logic [15:0] m_bcd;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
  endtask

  task automatic model_reset();
    cyc     = 0;
    m_bcd   = 16'h0000;
    exp_an  = 4'b1111;
    exp_seg = 7'h7F;
  endtask

  // Called right after a rising edge, with inputs still at their pre-edge values.
  task automatic model_edge();
    int  idx;
    bit  lit;
    logic [3:0] d;
    cyc++;
    idx = (cyc / RD + 3) % 4;
    if (blank) begin
      exp_an  = 4'b1111;
      exp_seg = 7'h7F;
    end else if (cyc % RD == 0) begin
      d   = 4'((m_bcd >> (4 * idx)) & 16'hF);
      lit = 1'b1;
`ifdef BCD_SEVENSEG_LZB_EN
      lit = (idx == 0) || ((m_bcd >> (4 * idx)) != 16'h0000);
`endif
      exp_an  = lit ? ~(4'b0001 << idx) : 4'b1111;
      exp_seg = lit ? seg_tab[d] : 7'h7F;
    end
    if (load) m_bcd = bcd;
  endtask

  task automatic step(input logic ld, input logic [15:0] val, input logic blk);
    load  = ld;
    bcd   = val;
    blank = blk;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("an", 16'(an), 16'(exp_an));
    check("seg", 16'(seg), 16'(exp_seg));
    check("dp", 16'(dp), 16'h1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, bcd, 1'b0);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_an", 16'(an), 16'hF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_dp", 16'(dp), 16'h1);
    rst_n = 1'b1;

    // Dark for three edges, first digit on the fourth.
    idle(RD);
    check("first_tick_an", 16'(an), 16'hE);
    check("first_tick_seg", 16'(seg), 16'h40);

    step(1'b1, 16'h2047, 1'b0);
    idle(20);
    step(1'b1, 16'h00A5, 1'b0);
    idle(20);

    // Load coinciding with the tick into the units slot.
    step(1'b1, 16'h0001, 1'b0);
    for (int i = 0; i < 4 * RD && ((cyc + 1) % (4 * RD)) != RD; i++) step(1'b0, bcd, 1'b0);
    step(1'b1, 16'h0009, 1'b0);
    check("load_on_tick_seg", 16'(seg), 16'h79);
    idle(4 * RD);
    check("load_on_tick_next", 16'(seg), 16'h10);
    idle(3);

    // Blank mid-slot for six cycles, then let the scan resume.
    step(1'b1, 16'h1234, 1'b0);
    idle(1);
    for (int i = 0; i < 6; i++) step(1'b0, bcd, 1'b1);
    idle(12);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] v;
      v = ($urandom_range(0, 7) == 0) ? 16'($urandom) : to_bcd(int'($urandom_range(0, 2047)));
      step($urandom_range(0, 3) == 0, v, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset mid-slot.
    step(1'b1, 16'h1987, 1'b0);
    idle(RD + 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", 16'(an), 16'hF);
    check("async_rst_seg", 16'(seg), 16'h7F);
    model_reset();
    @(negedge clk);
    load = 1'b0;
    rst_n = 1'b1;
    idle(4 * RD + 2);

    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 2) == 0, to_bcd(int'($urandom_range(0, 2047))),
           $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
